mem_bus_arbiter: RTL and testbench
==================================

// Module: mem_bus_arbiter
// PURPOSE
//  Shares one single-port synchronous RAM between the instruction-fetch (IF) and data (MEM) masters of the openmips core.
//  Fixed-priority arbitration (data wins) with an anti-starvation counter for IF; drives RAM strobes, counts RAM latency,
//  returns read data with a one-cycle ack pulse and raises pipeline stall requests toward ctrl while a master is waiting.
// PARAMETERS
//  ADDR_W      32  address width of both masters and the RAM
//  DATA_W      32  data width
//  MEM_LAT     2   cycles from first mem_ce_o cycle to mem_rdata_i valid (>=1)
//  STARVE_MAX  4   consecutive data grants allowed while inst_req_i waits (>=1)
// PORTS
//  clk             in   1        clock, all state on rising edge
//  rst             in   1        synchronous reset, active-low (rst==0 resets)
//  inst_req_i      in   1        IF read request, held until inst_ack_o
//  inst_addr_i     in   ADDR_W   IF address
//  inst_rdata_o    out  DATA_W   IF read data, valid with inst_ack_o
//  inst_ack_o      out  1        one-cycle completion pulse for IF
//  data_req_i      in   1        MEM request, held until data_ack_o
//  data_we_i       in   1        1=store, 0=load
//  data_sel_i      in   DATA_W/8 byte enables
//  data_addr_i     in   ADDR_W   MEM address
//  data_wdata_i    in   DATA_W   store data
//  data_rdata_o    out  DATA_W   load data, valid with data_ack_o
//  data_ack_o      out  1        one-cycle completion pulse for MEM
//  stallreq_if_o   out  1        inst_req_i & ~inst_ack_o (combinational)
//  stallreq_mem_o  out  1        data_req_i & ~data_ack_o (combinational)
//  mem_ce_o        out  1        RAM chip enable
//  mem_we_o        out  1        RAM write enable
//  mem_sel_o       out  DATA_W/8 RAM byte enables
//  mem_addr_o      out  ADDR_W   RAM address
//  mem_wdata_o     out  DATA_W   RAM write data
//  mem_rdata_i     in   DATA_W   RAM read data
// BEHAVIOUR
//  - Reset: state IDLE, starve count 0, all outputs 0 (stallreq_* follow their equation). Reset mid-transaction aborts: no ack.
//  - FSM IDLE -> BUSY -> ACK -> IDLE. No grant is made in BUSY or ACK.
//  - IDLE, cycle T: if any req, grant and latch winner's addr/we/sel/wdata; BUSY from T+1. Otherwise stay IDLE.
//  - Grant rule: data if data_req_i and (~inst_req_i or starve<STARVE_MAX); else inst if inst_req_i.
//  - Starve count: +1 on each data grant while inst_req_i=1 (saturates at STARVE_MAX); cleared on inst grant
//    and on any data grant with inst_req_i=0.
//  - BUSY: mem_ce_o=1 and mem_* = latched values, cycles T+1..T+MEM_LAT; inst grant drives mem_we_o=0, mem_sel_o all-ones.
//    mem_rdata_i sampled at end of cycle T+MEM_LAT.
//  - ACK, cycle T+MEM_LAT+1: mem_ce_o=0; winner's ack=1 and rdata_o=sampled data (store: rdata_o=0). rdata_o holds until next ack.
//  - Throughput: one transaction per MEM_LAT+2 cycles. Requester must drop or renew req the cycle after its ack;
//    req seen in IDLE is always a new request.
//  - req withdrawn during BUSY (flush): transaction completes, ack still pulses, master ignores it; no cancel of a store.
//  - Inputs other than req are don't-care outside IDLE (latched at grant).
// TESTING (MEM_LAT=2, STARVE_MAX=4)
//  - Reset: rst=0 for 2 cycles with reqs high -> all outputs 0, no ce; release -> grant in first IDLE cycle.
//  - Lone IF read addr 0x100 at T, RAM returns 0x3401_0020 -> mem_ce_o=1 T+1..T+2, inst_ack_o=1 at T+3 with that data.
//  - IF and MEM load at same T -> data served first (ack T+3), IF ack at T+7; stallreq_if_o high T..T+6.
//  - Continuous data reqs + held inst_req -> exactly 4 data acks, then inst ack, then data resumes.
//  - Store addr 0x8, sel 4'b0011, wdata 0xDEAD_BEEF -> mem_we_o=1, sel/wdata passed through T+1..T+2; data_ack_o at T+3, data_rdata_o=0.
//  - rst=0 at T+2 of a read -> mem_ce_o=0 at T+3, no ack ever; data_req_i dropped at T+1 (no reset) -> ack still at T+3.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Arbitrates one single-port synchronous RAM between the IF and MEM masters.
// Data has fixed priority; IF wins once STARVE_MAX consecutive data grants were made while it waited.
module mem_bus_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inst_req_i,
    input  logic [ADDR_W-1:0]     inst_addr_i,
    output logic [DATA_W-1:0]     inst_rdata_o,
    output logic                  inst_ack_o,
    input  logic                  data_req_i,
    input  logic                  data_we_i,
    input  logic [DATA_W/8-1:0]   data_sel_i,
    input  logic [ADDR_W-1:0]     data_addr_i,
    input  logic [DATA_W-1:0]     data_wdata_i,
    output logic [DATA_W-1:0]     data_rdata_o,
    output logic                  data_ack_o,
    output logic                  stallreq_if_o,
    output logic                  stallreq_mem_o,
    output logic                  mem_ce_o,
    output logic                  mem_we_o,
    output logic [DATA_W/8-1:0]   mem_sel_o,
    output logic [ADDR_W-1:0]     mem_addr_o,
    output logic [DATA_W-1:0]     mem_wdata_o,
    input  logic [DATA_W-1:0]     mem_rdata_i
);

    localparam int SEL_W = DATA_W / 8;
    localparam int CNT_W = $clog2(MEM_LAT + 1);
    localparam int STV_W = $clog2(STARVE_MAX + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_ACK  = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [STV_W-1:0]  starve_q, starve_d;
    logic              owner_data_q, owner_data_d;
    logic              we_q, we_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] irdata_q, irdata_d;
    logic [DATA_W-1:0] drdata_q, drdata_d;
    logic              grant_data;
    logic              grant_inst;

    assign grant_data = data_req_i && (!inst_req_i || (starve_q < STV_W'(STARVE_MAX)));
    assign grant_inst = inst_req_i && !grant_data;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        starve_d     = starve_q;
        owner_data_d = owner_data_q;
        we_d         = we_q;
        sel_d        = sel_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        irdata_d     = irdata_q;
        drdata_d     = drdata_q;
        case (state_q)
            S_IDLE: begin
                if (grant_data) begin
                    state_d      = S_BUSY;
                    cnt_d        = CNT_W'(1);
                    owner_data_d = 1'b1;
                    we_d         = data_we_i;
                    sel_d        = data_sel_i;
                    addr_d       = data_addr_i;
                    wdata_d      = data_wdata_i;
                    // grant_data with inst waiting implies starve_q < STARVE_MAX, so this saturates
                    starve_d     = inst_req_i ? starve_q + STV_W'(1) : '0;
                end else if (grant_inst) begin
                    state_d      = S_BUSY;
                    cnt_d        = CNT_W'(1);
                    owner_data_d = 1'b0;
                    we_d         = 1'b0;
                    sel_d        = '1;
                    addr_d       = inst_addr_i;
                    wdata_d      = '0;
                    starve_d     = '0;
                end
            end
            S_BUSY: begin
                if (cnt_q == CNT_W'(MEM_LAT)) begin
                    state_d = S_ACK;
                    if (owner_data_q) begin
                        drdata_d = we_q ? '0 : mem_rdata_i;
                    end else begin
                        irdata_d = mem_rdata_i;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_ACK:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            starve_q     <= '0;
            owner_data_q <= 1'b0;
            we_q         <= 1'b0;
            sel_q        <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            irdata_q     <= '0;
            drdata_q     <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            starve_q     <= starve_d;
            owner_data_q <= owner_data_d;
            we_q         <= we_d;
            sel_q        <= sel_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            irdata_q     <= irdata_d;
            drdata_q     <= drdata_d;
        end
    end

    // RAM strobes are only driven while a transfer is in flight
    assign mem_ce_o    = (state_q == S_BUSY);
    assign mem_we_o    = mem_ce_o & we_q;
    assign mem_sel_o   = mem_ce_o ? sel_q : '0;
    assign mem_addr_o  = mem_ce_o ? addr_q : '0;
    assign mem_wdata_o = mem_ce_o ? wdata_q : '0;

    assign inst_ack_o   = (state_q == S_ACK) & ~owner_data_q;
    assign data_ack_o   = (state_q == S_ACK) & owner_data_q;
    assign inst_rdata_o = irdata_q;
    assign data_rdata_o = drdata_q;

    assign stallreq_if_o  = inst_req_i & ~inst_ack_o;
    assign stallreq_mem_o = data_req_i & ~data_ack_o;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios plus randomized traffic checked
// against a transaction-level model (grant cycle, fixed latency, starve count).
module tb_mem_bus_arbiter;

    localparam int LAT  = 2;
    localparam int SMAX = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        ireq, dreq, dwe;
    logic [31:0] iaddr, daddr, dwdata;
    logic [3:0]  dsel;
    logic [31:0] inst_rdata, data_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        inst_ack, data_ack, st_if, st_mem, mem_ce, mem_we;
    logic [3:0]  mem_sel;

    int checks = 0;
    int errors = 0;
    int ce_run = 0;

    mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst(rst),
        .inst_req_i(ireq), .inst_addr_i(iaddr), .inst_rdata_o(inst_rdata), .inst_ack_o(inst_ack),
        .data_req_i(dreq), .data_we_i(dwe), .data_sel_i(dsel), .data_addr_i(daddr),
        .data_wdata_i(dwdata), .data_rdata_o(data_rdata), .data_ack_o(data_ack),
        .stallreq_if_o(st_if), .stallreq_mem_o(st_mem),
        .mem_ce_o(mem_ce), .mem_we_o(mem_we), .mem_sel_o(mem_sel), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ram_val(input logic [31:0] a);
        if (a == 32'h0000_0100) return 32'h3401_0020;
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    // Behavioural RAM: read data is only valid in the MEM_LAT-th consecutive ce cycle
    always @(posedge clk) ce_run <= mem_ce ? ce_run + 1 : 0;
    assign mem_rdata = (mem_ce && ce_run == LAT - 1) ? ram_val(mem_addr) : 32'hBAD0_0BAD;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        ireq = 1'b1; iaddr = 32'h300;
        dreq = 1'b1; daddr = 32'h40; dwe = 1'b0; dsel = 4'hF; dwdata = 32'h0;
        for (int k = 0; k < 2; k++) begin
            cyc(); #1;
            checks++;
            if ({mem_ce, mem_we, mem_sel, mem_addr, mem_wdata, inst_ack, data_ack, inst_rdata, data_rdata} !== '0) begin
                errors++;
                $display("FAIL reset_outputs: ce=%b we=%b ack=%b/%b irdata=%h drdata=%h expected all 0",
                         mem_ce, mem_we, inst_ack, data_ack, inst_rdata, data_rdata);
            end
            checks++;
            if ({st_if, st_mem} !== 2'b11) begin
                errors++;
                $display("FAIL reset_stallreq: got %b expected 11", {st_if, st_mem});
            end
        end
        cyc(); rst = 1'b1; #1;
        checks++;
        if (mem_ce !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_idle: ce=%b expected 0", mem_ce);
        end
        cyc(); #1;
        checks++;
        if ({mem_ce, mem_we, mem_addr} !== {1'b1, 1'b0, 32'h40}) begin
            errors++;
            $display("FAIL reset_first_grant: ce=%b we=%b addr=%h expected 1 0 00000040", mem_ce, mem_we, mem_addr);
        end
        ireq = 1'b0; dreq = 1'b0; rst = 1'b0;
        cyc(); rst = 1'b1; #1;
    endtask

    task automatic test_lone_if();
        cyc(); ireq = 1'b1; iaddr = 32'h100; #1;
        checks++;
        if ({st_if, mem_ce} !== 2'b10) begin
            errors++;
            $display("FAIL lone_if_T: stall/ce=%b expected 10", {st_if, mem_ce});
        end
        for (int k = 1; k <= LAT; k++) begin
            cyc(); #1;
            checks++;
            if ({mem_ce, mem_we, mem_sel, mem_addr} !== {1'b1, 1'b0, 4'hF, 32'h100}) begin
                errors++;
                $display("FAIL lone_if_busy: ce=%b we=%b sel=%h addr=%h", mem_ce, mem_we, mem_sel, mem_addr);
            end
        end
        cyc(); #1;
        checks++;
        if ({inst_ack, data_ack, mem_ce, st_if, inst_rdata} !== {4'b1000, 32'h3401_0020}) begin
            errors++;
            $display("FAIL lone_if_ack: ack=%b dack=%b ce=%b stall=%b rdata=%h expected 1 0 0 0 34010020",
                     inst_ack, data_ack, mem_ce, st_if, inst_rdata);
        end
        cyc(); ireq = 1'b0; #1;
        checks++;
        if ({inst_ack, inst_rdata} !== {1'b0, 32'h3401_0020}) begin
            errors++;
            $display("FAIL lone_if_hold: ack=%b rdata=%h expected 0 34010020", inst_ack, inst_rdata);
        end
    endtask

    task automatic test_collision();
        for (int t = 0; t < 8; t++) begin
            cyc();
            if (t == 0) begin
                ireq = 1'b1; iaddr = 32'h104;
                dreq = 1'b1; daddr = 32'h200; dwe = 1'b0; dsel = 4'hF;
            end
            if (t == 4) dreq = 1'b0;
            #1;
            checks++;
            if ({st_if, data_ack, inst_ack} !== {t <= 6, t == 3, t == 7}) begin
                errors++;
                $display("FAIL collision_t%0d: stall_if/dack/iack=%b expected %b",
                         t, {st_if, data_ack, inst_ack}, {t <= 6, t == 3, t == 7});
            end
            if (t == 3) begin
                checks++;
                if (data_rdata !== ram_val(32'h200)) begin
                    errors++;
                    $display("FAIL collision_drdata: got %h expected %h", data_rdata, ram_val(32'h200));
                end
            end
            if (t == 7) begin
                checks++;
                if (inst_rdata !== ram_val(32'h104)) begin
                    errors++;
                    $display("FAIL collision_irdata: got %h expected %h", inst_rdata, ram_val(32'h104));
                end
            end
        end
        cyc(); ireq = 1'b0; #1;
    endtask

    task automatic test_starvation();
        int n = 0;
        logic [5:0] seq = '0;
        bit both = 1'b0;
        cyc(); dreq = 1'b1; dwe = 1'b0; dsel = 4'hF; daddr = 32'h400; ireq = 1'b1; iaddr = 32'h500; #1;
        for (int c = 0; c < 60 && n < 6; c++) begin
            if (data_ack && inst_ack) both = 1'b1;
            if (data_ack) begin seq[n] = 1'b1; n++; end
            else if (inst_ack) begin seq[n] = 1'b0; n++; end
            cyc();
            if (inst_ack) ireq = 1'b0;
            if (data_ack) daddr = daddr + 32'h4;
            #1;
        end
        checks++;
        if (n != 6 || seq !== 6'b10_1111 || both) begin
            errors++;
            $display("FAIL starvation_order: acks=%0d seq=%b both=%b expected 6 101111 0", n, seq, both);
        end
        dreq = 1'b0;
        repeat (LAT + 3) cyc();
    endtask

    task automatic test_store();
        cyc(); dreq = 1'b1; dwe = 1'b1; daddr = 32'h8; dsel = 4'b0011; dwdata = 32'hDEAD_BEEF; #1;
        for (int k = 1; k <= LAT; k++) begin
            cyc();
            dwe = 1'($urandom); daddr = $urandom; dsel = 4'($urandom); dwdata = $urandom;
            #1;
            checks++;
            if ({mem_ce, mem_we, mem_sel, mem_addr, mem_wdata} !== {2'b11, 4'b0011, 32'h8, 32'hDEAD_BEEF}) begin
                errors++;
                $display("FAIL store_busy: ce=%b we=%b sel=%b addr=%h wdata=%h", mem_ce, mem_we, mem_sel, mem_addr, mem_wdata);
            end
        end
        cyc(); #1;
        checks++;
        if ({data_ack, inst_ack, data_rdata} !== {2'b10, 32'h0}) begin
            errors++;
            $display("FAIL store_ack: dack=%b iack=%b rdata=%h expected 1 0 00000000", data_ack, inst_ack, data_rdata);
        end
        cyc(); dreq = 1'b0; #1;
    endtask

    task automatic test_abort_flush();
        bit seen = 1'b0;
        cyc(); ireq = 1'b1; iaddr = 32'h600; #1;
        cyc(); #1;
        cyc(); rst = 1'b0; #1;
        checks++;
        if (mem_ce !== 1'b1) begin
            errors++;
            $display("FAIL abort_busy: ce=%b expected 1", mem_ce);
        end
        cyc(); rst = 1'b1; ireq = 1'b0; #1;
        checks++;
        if ({mem_ce, inst_ack, inst_rdata, data_rdata} !== '0) begin
            errors++;
            $display("FAIL abort_reset: ce=%b ack=%b irdata=%h drdata=%h expected all 0", mem_ce, inst_ack, inst_rdata, data_rdata);
        end
        for (int k = 0; k < 6; k++) begin
            cyc(); #1;
            if (inst_ack || data_ack || mem_ce) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL abort_no_ack: activity seen=%b expected 0", seen);
        end
        cyc(); dreq = 1'b1; dwe = 1'b0; dsel = 4'hF; daddr = 32'h700; #1;
        cyc(); dreq = 1'b0; #1;
        cyc(); #1;
        cyc(); #1;
        checks++;
        if ({data_ack, st_mem, data_rdata} !== {2'b10, ram_val(32'h700)}) begin
            errors++;
            $display("FAIL flush_ack: dack=%b stall=%b rdata=%h expected 1 0 %h", data_ack, st_mem, data_rdata, ram_val(32'h700));
        end
    endtask

    task automatic test_random();
        int g = -100;
        int starve = 0;
        bit gd = 1'b0, gwe = 1'b0, pi = 1'b0, pd = 1'b0;
        bit busy, ackc, idle;
        logic [31:0] ga = '0, gw = '0, exp_ir = '0, exp_dr = '0;
        logic [3:0] gs = '0;
        cyc(); rst = 1'b0; ireq = 1'b0; dreq = 1'b0; #1;
        cyc(); rst = 1'b1; #1;
        for (int c = 0; c < 800; c++) begin
            cyc();
            busy = (c >= g + 1) && (c <= g + LAT);
            ackc = (c == g + LAT + 1);
            idle = (c >= g + LAT + 2);
            if (!ireq) begin
                if ($urandom % 3 == 0) begin ireq = 1'b1; iaddr = $urandom; end
            end else if (pi) begin
                ireq = 1'($urandom); iaddr = $urandom;
            end
            if (!dreq || pd) begin
                if (!dreq) dreq = ($urandom % 2 == 0);
                else       dreq = 1'($urandom);
                dwe = 1'($urandom); dsel = 4'($urandom); daddr = $urandom; dwdata = $urandom;
            end
            if (!idle) begin
                dwe = 1'($urandom); dsel = 4'($urandom); daddr = $urandom; dwdata = $urandom; iaddr = $urandom;
            end
            #1;
            checks++;
            if (mem_ce !== busy) begin
                errors++;
                $display("FAIL rand_ce c=%0d: got %b expected %b", c, mem_ce, busy);
            end
            if (busy) begin
                checks++;
                if ({mem_we, mem_sel, mem_addr} !== {gd ? gwe : 1'b0, gd ? gs : 4'hF, ga} ||
                    (gd && mem_wdata !== gw)) begin
                    errors++;
                    $display("FAIL rand_strobes c=%0d: we=%b sel=%h addr=%h wdata=%h expected %b %h %h %h",
                             c, mem_we, mem_sel, mem_addr, mem_wdata, gd ? gwe : 1'b0, gd ? gs : 4'hF, ga, gw);
                end
            end
            if (ackc) begin
                if (gd) exp_dr = gwe ? 32'h0 : ram_val(ga);
                else    exp_ir = ram_val(ga);
            end
            checks++;
            if ({inst_ack, data_ack} !== {ackc && !gd, ackc && gd}) begin
                errors++;
                $display("FAIL rand_ack c=%0d: iack/dack=%b%b expected %b%b", c, inst_ack, data_ack, ackc && !gd, ackc && gd);
            end
            checks++;
            if (inst_rdata !== exp_ir || data_rdata !== exp_dr) begin
                errors++;
                $display("FAIL rand_rdata c=%0d: i=%h d=%h expected %h %h", c, inst_rdata, data_rdata, exp_ir, exp_dr);
            end
            checks++;
            if ({st_if, st_mem} !== {ireq && !(ackc && !gd), dreq && !(ackc && gd)}) begin
                errors++;
                $display("FAIL rand_stall c=%0d: got %b%b", c, st_if, st_mem);
            end
            pi = ackc && !gd;
            pd = ackc && gd;
            if (idle && (ireq || dreq)) begin
                g = c;
                if (dreq && (!ireq || starve < SMAX)) begin
                    gd = 1'b1; gwe = dwe; gs = dsel; ga = daddr; gw = dwdata;
                    starve = ireq ? ((starve + 1 > SMAX) ? SMAX : starve + 1) : 0;
                end else begin
                    gd = 1'b0; ga = iaddr;
                    starve = 0;
                end
            end
        end
        ireq = 1'b0; dreq = 1'b0;
    endtask

    initial begin
        rst = 1'b0; ireq = 1'b0; dreq = 1'b0; dwe = 1'b0;
        iaddr = '0; daddr = '0; dwdata = '0; dsel = '0;
        test_reset();
        test_lone_if();
        test_collision();
        test_starvation();
        test_store();
        test_abort_flush();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
